// File: rtl/tmds_chnl_bond.sv
// tmds_chnl_bond
//   Per-channel deskew stage of the TMDS receive path (one instance per channel).
//   Incoming decoded-domain words are registered and written into a 16-entry
//   circular buffer while all three channels are word-locked. The rising edge
//   of a control-token run (the start of blanking) freezes the read pointer on
//   the buffer slot that holds the first token. The channel then holds there
//   until both siblings report the same event, and streams aligned data from
//   that point on.
//
// Ports
//   CLK            pixel clock
//   RESET          synchronous, active-high reset
//   RAW_DATA       phase-aligned word from the deserializer
//   I_AM_VLD       this channel's deserializer is word-locked
//   OTHER_CH0_VLD  sibling A is word-locked
//   OTHER_CH1_VLD  sibling B is word-locked
//   OTHER_CH0_RDY  sibling A has found its blanking edge
//   OTHER_CH1_RDY  sibling B has found its blanking edge
//   I_AM_RDY       this channel has found its blanking edge (HOLD or RUN)
//   BOND_OK        all three channels aligned; S_DATA is deskewed
//   S_DATA         deskewed word towards the TMDS decoder

module tmds_chnl_bond #(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned MAX_HOLD = 14
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] RAW_DATA,
  input  logic              I_AM_VLD,
  input  logic              OTHER_CH0_VLD,
  input  logic              OTHER_CH1_VLD,
  input  logic              OTHER_CH0_RDY,
  input  logic              OTHER_CH1_RDY,
  output logic              I_AM_RDY,
  output logic              BOND_OK,
  output logic [DATA_W-1:0] S_DATA
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  // TMDS control tokens (C1C0 = 00, 01, 10, 11)
  localparam logic [DATA_W-1:0] TOK0 = DATA_W'(10'h354);
  localparam logic [DATA_W-1:0] TOK1 = DATA_W'(10'h0AB);
  localparam logic [DATA_W-1:0] TOK2 = DATA_W'(10'h154);
  localparam logic [DATA_W-1:0] TOK3 = DATA_W'(10'h2AB);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t              state_q,    state_d;
  logic [DATA_W-1:0]   raw_q;
  logic                ctkn_q;
  logic [ADDR_W-1:0]   wa_q,       wa_d;
  logic [ADDR_W-1:0]   ra_q,       ra_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                rdy_q,      rdy_d;
  logic                bond_q,     bond_d;
  logic [DATA_W-1:0]   s_data_q,   s_data_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                all_vld;
  logic                all_rdy;
  logic                sib_rdy;
  logic                ctkn;
  logic                blnk_bgn;
  logic                cur_active;
  logic                nxt_active;
  logic [DATA_W-1:0]   rd_word;

  assign all_vld  = I_AM_VLD & OTHER_CH0_VLD & OTHER_CH1_VLD;
  assign sib_rdy  = OTHER_CH0_RDY & OTHER_CH1_RDY;
  assign all_rdy  = rdy_q & sib_rdy;

  assign ctkn     = (raw_q == TOK0) | (raw_q == TOK1) |
                    (raw_q == TOK2) | (raw_q == TOK3);
  assign blnk_bgn = ctkn & ~ctkn_q & all_vld;

  // Asynchronous read; a write to the same slot in this cycle lands at the
  // clock edge, so the old content is what gets registered into S_DATA.
  assign rd_word  = mem_q[ra_q];

  // Buffer storage is deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (all_vld) begin
      mem_q[wa_q] <= raw_q;
    end
  end

  always_comb begin
    if (all_vld) begin
      wa_d = wa_q + 1'b1;
    end else begin
      wa_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    ra_d       = ra_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        ra_d = '0;
        if (all_vld) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Latch the slot the first token is being written to this cycle.
        if (blnk_bgn) begin
          state_d    = ST_HOLD;
          ra_d       = wa_q;
          hold_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (all_rdy) begin
          state_d = ST_RUN;
          ra_d    = ra_q + 1'b1;
        end else if (hold_cnt_q == HOLD_W'(MAX_HOLD)) begin
          // Writer is about to lap the frozen reader: give up this edge.
          state_d = ST_WAIT;
        end
      end
      ST_RUN: begin
        ra_d = ra_q + 1'b1;
        if (!sib_rdy) begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ra_d    = '0;
      end
    endcase

    // Lock loss on any channel wins over every other transition.
    if (!all_vld) begin
      state_d = ST_IDLE;
      ra_d    = '0;
    end
  end

  // Status flags and S_DATA follow the next state so they change in the same
  // cycle the state is entered. S_DATA additionally requires the current
  // state to be HOLD/RUN so that the WAIT->HOLD edge, where ra is only being
  // loaded, emits zero instead of a stale slot.
  always_comb begin
    cur_active = (state_q == ST_HOLD) || (state_q == ST_RUN);
    nxt_active = (state_d == ST_HOLD) || (state_d == ST_RUN);
    rdy_d      = nxt_active;
    bond_d     = (state_d == ST_RUN);
    s_data_d   = '0;
    if (cur_active && nxt_active) begin
      s_data_d = rd_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      raw_q      <= '0;
      ctkn_q     <= 1'b0;
      wa_q       <= '0;
      ra_q       <= '0;
      hold_cnt_q <= '0;
      rdy_q      <= 1'b0;
      bond_q     <= 1'b0;
      s_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      raw_q      <= RAW_DATA;
      ctkn_q     <= ctkn;
      wa_q       <= wa_d;
      ra_q       <= ra_d;
      hold_cnt_q <= hold_cnt_d;
      rdy_q      <= rdy_d;
      bond_q     <= bond_d;
      s_data_q   <= s_data_d;
    end
  end

  assign I_AM_RDY = rdy_q;
  assign BOND_OK  = bond_q;
  assign S_DATA   = s_data_q;

endmodule
